// File: rtl/fpdiv_pkg.sv
// fpdiv_pkg: shared state encoding and constants for the FP32 divider scheduler
package fpdiv_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   localparam logic [31:0] QNAN_F32 = 32'h7FC00000;
   localparam int TIMEOUT_DEF = 64;
endpackage

// File: rtl/fpdiv_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wraparound
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   idx
);
   logic [IW-1:0] j;
   // walk the search order backwards so the closest requester to ptr is written last
   always_comb begin
      gnt = '0;
      idx = '0;
      j = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = IW'((int'(ptr) + k) % NREQ);
         if (req[j]) begin
            gnt = '0;
            gnt[j] = 1'b1;
            idx = j;
         end
      end
   end
endmodule

// File: rtl/fpdiv_sched.sv
// fpdiv_sched: round-robin sharing of one multi-cycle FP32 divider with completion timeout
module fpdiv_sched
   import fpdiv_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int TW = 7
) (
   input  logic              clock,
   input  logic              resetb,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*32-1:0] req_a,
   input  logic [NREQ*32-1:0] req_b,
   output logic [NREQ-1:0]   resp_valid,
   input  logic [NREQ-1:0]   resp_ready,
   output logic [31:0]       resp_data,
   output logic              resp_err,
   output logic              div_start,
   output logic [31:0]       div_a,
   output logic [31:0]       div_b,
   input  logic              div_done,
   input  logic [31:0]       div_result,
   output logic [7:0]        io_byte,
   output logic              busy
);
   localparam int IW = $clog2(NREQ);
   state_t state, state_nx;
   logic [IW-1:0] rr_ptr, grant, win_idx;
   logic [NREQ-1:0] win_gnt;
   logic [TW-1:0] counter;
   logic to_hit, finish, handshake;
   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
      .req(req_valid),
      .ptr(rr_ptr),
      .gnt(win_gnt),
      .idx(win_idx)
   );
   always_comb begin
      to_hit = counter == TW'(TIMEOUT - 1);
      finish = state == WAIT && (div_done || to_hit);
      handshake = state == RESP && resp_ready[grant];
      state_nx = state == IDLE  ? (|req_valid ? ISSUE : IDLE) :
                 state == ISSUE ? WAIT :
                 state == WAIT  ? (finish ? RESP : WAIT) :
                 (handshake ? IDLE : RESP);
      req_ready = state == IDLE ? win_gnt : '0;
      div_start = state == ISSUE;
      busy = state != IDLE;
   end
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) state <= IDLE;
      else state <= state_nx;
   end
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         rr_ptr <= '0;
         grant <= '0;
         counter <= '0;
         div_a <= '0;
         div_b <= '0;
         resp_valid <= '0;
         resp_data <= '0;
         resp_err <= 1'b0;
         io_byte <= '0;
      end else begin
         if (state == IDLE && |req_valid) begin
            grant <= win_idx;
            div_a <= req_a[32*win_idx +: 32];
            div_b <= req_b[32*win_idx +: 32];
         end
         counter <= state == ISSUE ? '0 : state == WAIT ? counter + 1'b1 : counter;
         // a completion on the timeout cycle still counts as a real result
         if (finish) begin
            resp_data <= div_done ? div_result : QNAN_F32;
            resp_err <= !div_done;
            resp_valid <= NREQ'(1) << grant;
         end
         if (handshake) begin
            resp_valid <= '0;
            rr_ptr <= grant == IW'(NREQ - 1) ? '0 : grant + 1'b1;
            if (!resp_err) io_byte <= resp_data[7:0];
         end
      end
   end
endmodule

// File: tb/tb_fpdiv_sched.sv
// tb_fpdiv_sched: directed and random checks of fpdiv_sched against a behavioural scheduler model
module tb_fpdiv_sched;
   localparam int TIMEOUT = 64;
   localparam logic [31:0] QNAN = 32'h7FC00000;
   logic clock = 1'b0;
   logic resetb;
   logic [3:0] req_valid, req_ready, resp_valid, resp_ready;
   logic [127:0] req_a, req_b;
   logic [31:0] resp_data, div_a, div_b, div_result;
   logic resp_err, div_start, div_done, busy;
   logic [7:0] io_byte;
   int total = 0;
   int bad = 0;
   int m_ptr = 0;
   logic [7:0] m_io = 8'h00;

   fpdiv_sched #(.NREQ(4), .TIMEOUT(TIMEOUT), .TW(7)) dut (
      .clock(clock), .resetb(resetb),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
      .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_done(div_done), .div_result(div_result),
      .io_byte(io_byte), .busy(busy)
   );

   always #5 clock = ~clock;

   initial begin
      #3000000;
      $display("FAIL watchdog obs=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, o, e);
      end
   endtask

   function automatic int pick(input logic [3:0] v, input int p);
      for (int k = 0; k < 4; k++)
         if (v[(p + k) % 4]) return (p + k) % 4;
      return 0;
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 0);
      chk({tag, "_resp_valid"}, 32'(resp_valid), 0);
      chk({tag, "_resp_data"}, resp_data, 0);
      chk({tag, "_resp_err"}, 32'(resp_err), 0);
      chk({tag, "_div_start"}, 32'(div_start), 0);
      chk({tag, "_div_a"}, div_a, 0);
      chk({tag, "_div_b"}, div_b, 0);
      chk({tag, "_io_byte"}, 32'(io_byte), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
   endtask

   // lat: WAIT cycle on which div_done is driven (0 = never)
   task automatic run_op(input string tag, input logic [3:0] vmask, input int lat,
                         input logic [31:0] res, input int hold, input bit keep);
      int w, k, exp_c;
      logic [3:0] oh;
      logic [31:0] exp_d;
      logic exp_e;
      w = pick(vmask, m_ptr);
      oh = 4'b0001 << w;
      req_valid = vmask;
      #1;
      chk({tag, "_idle_ready"}, 32'(req_ready), 32'(oh));
      chk({tag, "_idle_busy"}, 32'(busy), 0);
      @(posedge clock); #1;
      chk({tag, "_issue_start"}, 32'(div_start), 1);
      chk({tag, "_issue_a"}, div_a, req_a[32*w +: 32]);
      chk({tag, "_issue_b"}, div_b, req_b[32*w +: 32]);
      chk({tag, "_issue_ready"}, 32'(req_ready), 0);
      @(posedge clock); #1;
      chk({tag, "_wait_start"}, 32'(div_start), 0);
      k = 1;
      while (resp_valid == 4'b0 && k <= TIMEOUT + 5) begin
         if (k == lat) begin
            div_done = 1'b1;
            div_result = res;
         end
         @(posedge clock); #1;
         div_done = 1'b0;
         div_result = $urandom;
         k++;
      end
      exp_e = !(lat >= 1 && lat <= TIMEOUT);
      exp_c = exp_e ? TIMEOUT : lat;
      exp_d = exp_e ? QNAN : res;
      chk({tag, "_wait_cycles"}, 32'(k - 1), 32'(exp_c));
      chk({tag, "_resp_valid"}, 32'(resp_valid), 32'(oh));
      chk({tag, "_resp_data"}, resp_data, exp_d);
      chk({tag, "_resp_err"}, 32'(resp_err), 32'(exp_e));
      for (int h = 0; h < hold; h++) begin
         resp_ready = 4'($urandom) & ~oh;
         #1;
         chk({tag, "_hold_valid"}, 32'(resp_valid), 32'(oh));
         chk({tag, "_hold_data"}, resp_data, exp_d);
         chk({tag, "_hold_ready"}, 32'(req_ready), 0);
         chk({tag, "_hold_busy"}, 32'(busy), 1);
         @(posedge clock); #1;
      end
      resp_ready = oh;
      @(posedge clock); #1;
      resp_ready = 4'b0;
      if (!exp_e) m_io = exp_d[7:0];
      m_ptr = (w + 1) % 4;
      chk({tag, "_done_valid"}, 32'(resp_valid), 0);
      chk({tag, "_done_busy"}, 32'(busy), 0);
      chk({tag, "_io_byte"}, 32'(io_byte), 32'(m_io));
      if (!keep) req_valid = 4'b0;
   endtask

   initial begin
      resetb = 1'b0;
      req_valid = 4'b0;
      resp_ready = 4'b0;
      req_a = '0;
      req_b = '0;
      div_done = 1'b0;
      div_result = '0;
      #12;
      chk_zero("reset");
      @(posedge clock); #1;
      resetb = 1'b1;

      // fairness: every requester valid continuously
      for (int i = 0; i < 4; i++) begin
         req_a[32*i +: 32] = 32'h3F800000 + 32'(i);
         req_b[32*i +: 32] = 32'h40000000 + 32'(i * 16);
      end
      for (int n = 0; n < 5; n++)
         run_op("fair", 4'b1111, 3 + n, 32'hA0000000 + 32'(n), 0, n < 4);
      req_valid = 4'b0;

      // single request, known quotient of -33.0 / pi
      req_a[31:0] = 32'hC2040000;
      req_b[31:0] = 32'h40490FDB;
      run_op("single", 4'b0001, 20, 32'hC128114F, 0, 0);
      chk("single_io", 32'(io_byte), 32'h4F);

      // backpressure on requester 1 while all others keep requesting
      run_op("bp", 4'b1111, 7, 32'h12345601, 50, 0);

      // timeout, then a stale completion that must be ignored
      run_op("tmo", 4'b0001, 0, 32'h0, 2, 0);
      repeat (10) @(posedge clock);
      #1;
      div_done = 1'b1;
      div_result = 32'hDEADBEEF;
      @(posedge clock); #1;
      div_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("late_valid", 32'(resp_valid), 0);
         chk("late_busy", 32'(busy), 0);
         chk("late_io", 32'(io_byte), 32'(m_io));
         @(posedge clock); #1;
      end

      // completion on the timeout cycle: 1.0 / pi
      req_a[63:32] = 32'h3F800000;
      req_b[63:32] = 32'h40490FDB;
      run_op("race", 4'b0010, TIMEOUT, 32'h3EA2F983, 1, 0);
      chk("race_io", 32'(io_byte), 32'h83);

      // reset while waiting on requester 3
      req_valid = 4'b1000;
      @(posedge clock); #1;
      req_valid = 4'b0;
      @(posedge clock); #1;
      @(posedge clock); #3;
      resetb = 1'b0;
      #1;
      chk_zero("midrst");
      m_ptr = 0;
      m_io = 8'h00;
      repeat (3) @(posedge clock);
      #1;
      resetb = 1'b1;
      div_done = 1'b1;
      div_result = 32'hCAFEF00D;
      @(posedge clock); #1;
      div_done = 1'b0;
      chk("postrst_valid", 32'(resp_valid), 0);
      chk("postrst_busy", 32'(busy), 0);
      run_op("postrst_ptr", 4'b0101, 5, 32'h11111111, 0, 0);
      run_op("postrst_r2", 4'b0100, 9, 32'h22222222, 0, 0);

      // random traffic
      for (int n = 0; n < 25; n++) begin
         req_a = {$urandom, $urandom, $urandom, $urandom};
         req_b = {$urandom, $urandom, $urandom, $urandom};
         run_op("rand", 4'($urandom_range(1, 15)),
                ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40),
                $urandom, $urandom_range(0, 3), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fpdiv_sched.md
Name: fpdiv_sched

Overview:
- Round-robin scheduler that shares one multi-cycle FP32 divider in the user project among NREQ requesters.
- Per requester: accepts an operand pair through a valid/ready handshake, issues it to the divider, waits for completion, and returns the quotient through a per-requester response handshake.
- Enforces a completion timeout.
- Mirrors the low byte of the last completed quotient onto io_byte, which drives mprj_io[7:0] for bring-up observation.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 64, max cycles in WAIT before an error response (>=2).
- TW, 7, timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clock  in  1  system clock
- resetb  in  1  asynchronous active-low reset
- req_valid  in  NREQ  operand pair valid, one bit per requester
- req_ready  out  NREQ  operand accepted, one-hot or zero
- req_a  in  NREQ*32  dividends; requester i uses bits [32i+31:32i]
- req_b  in  NREQ*32  divisors, same packing as req_a
- resp_valid  out  NREQ  response valid, one-hot or zero
- resp_ready  in  NREQ  response accepted
- resp_data  out  32  quotient, shared by all requesters
- resp_err  out  1  response is a timeout error
- div_start  out  1  one-cycle start pulse to the divider
- div_a  out  32  dividend to the divider
- div_b  out  32  divisor to the divider
- div_done  in  1  divider completion pulse
- div_result  in  32  divider quotient, valid with div_done
- io_byte  out  8  low byte of the last accepted quotient
- busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, release synchronous to clock):
  - state=IDLE; rr_ptr=0; grant=0; counter=0.
  - All outputs 0: req_ready, resp_valid, resp_data, resp_err, div_start, div_a, div_b, io_byte, busy.
  - Reset mid-operation abandons the transaction with no response. A div_done arriving later is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, the winner g is the first set bit searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[g]=1 combinationally in that same cycle; all other req_ready bits are 0.
  - On the clock edge: latch g and the operands; transfer to ISSUE.
  - req_ready is never asserted outside IDLE.
- ISSUE: div_start=1 for exactly one cycle; div_a/div_b hold the latched operands from ISSUE through WAIT. Counter cleared. Next state is WAIT.
- WAIT:
  - Counter increments each cycle.
  - If div_done=1: latch div_result into resp_data; resp_err=0; go to RESP.
  - Else if counter==TIMEOUT-1: resp_data=32'h7FC00000 (qNaN); resp_err=1; go to RESP.
  - If div_done coincides with the timeout cycle, div_done wins.
- RESP:
  - resp_valid[g]=1, registered. resp_data and resp_err stay stable until the handshake.
  - On resp_ready[g]=1: resp_valid clears; rr_ptr=(g+1) mod NREQ; go to IDLE.
  - io_byte<=resp_data[7:0] only when resp_err=0.
  - resp_ready bits for other requesters are ignored.
- Throughput: 1 IDLE + 1 ISSUE + L divider cycles + 1 RESP minimum per operation. A new grant can occur in the cycle after the RESP handshake.
- div_done outside WAIT is ignored, including late completions after a timeout.
- A requester dropping req_valid before grant is legal and simply loses arbitration. Operands are sampled only at acceptance.
- No arithmetic is done here; operands and results pass through bit-exact.

Decomposition:
- Shared package fpdiv_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP);
  - the constant QNAN_F32=32'h7FC00000;
  - the default TIMEOUT.
- One sub-module: rr_arbiter (NREQ-wide, combinational). Inputs: request vector and rr_ptr. Outputs: one-hot grant and the encoded index.
- FSM, timeout counter and output registers stay in fpdiv_sched.

Test Plan:
1. Single request: requester 0 sends a=32'hC2040000 (-33.0), b=32'h40490FDB (pi); the model divider returns R after 20 cycles. Required: div_start pulses once; resp_valid=4'b0001; resp_data=R; resp_err=0; io_byte=8'h4F.
2. Fairness: all four req_valid held high continuously, each request distinct. Required: grant order 0,1,2,3,0 across five operations; exactly one req_ready bit high per IDLE cycle.
3. Timeout: the model never asserts div_done. Required: RESP is entered TIMEOUT cycles after ISSUE with resp_data=32'h7FC00000 and resp_err=1; io_byte unchanged. A div_done injected 10 cycles later is ignored and no response is produced.
4. Backpressure: hold resp_ready[1]=0 for 50 cycles while requester 1 is in RESP. Required: resp_valid and resp_data stable; busy=1; no new grant; req_ready=0 throughout.
5. Edge race: div_done on the timeout cycle, 1.0/pi. Required: resp_err=0; io_byte=8'h83.
6. Reset mid-WAIT: deassert resetb for 3 cycles. Required: all outputs 0 immediately on assertion; rr_ptr=0 after release; the next request from requester 2 is granted normally.
